// File: rtl/etroc_stream_pkg.sv
// Shared definitions for the L1 event stream: frame word layouts, type codes and FSM encoding.
package etroc_stream_pkg;

  localparam int unsigned WORD_W = 40;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned TDC_W  = 29;
  localparam int unsigned BCID_W = 12;
  localparam int unsigned L1_W   = 8;
  localparam int unsigned CNT_W  = 9;

  localparam logic [1:0]        TYPE_HDR  = 2'b11;
  localparam logic [1:0]        TYPE_DATA = 2'b10;
  localparam logic [1:0]        TYPE_TRL  = 2'b01;
  localparam logic [BCID_W-1:0] HDR_MARK  = 12'hA5C;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]        typ;
    logic [5:0]        rsvd;
    logic [L1_W-1:0]   l1;
    logic [BCID_W-1:0] bcid;
    logic [BCID_W-1:0] mark;
  } hdr_word_t;

  typedef struct packed {
    logic [1:0]       typ;
    logic             rsvd;
    logic [PIX_W-1:0] pix;
    logic [TDC_W-1:0] tdc;
  } data_word_t;

  typedef struct packed {
    logic [1:0]       typ;
    logic             abort;
    logic [CNT_W-1:0] hit_cnt;
    logic [PIX_W-1:0] xsum;
    logic [19:0]      rsvd;
  } trl_word_t;

  function automatic logic [WORD_W-1:0] mk_hdr(input logic [L1_W-1:0] l1,
                                                input logic [BCID_W-1:0] bcid);
    hdr_word_t w;
    w.typ  = TYPE_HDR;
    w.rsvd = '0;
    w.l1   = l1;
    w.bcid = bcid;
    w.mark = HDR_MARK;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] mk_data(input logic [PIX_W-1:0] pix,
                                                 input logic [TDC_W-1:0] tdc);
    data_word_t w;
    w.typ  = TYPE_DATA;
    w.rsvd = 1'b0;
    w.pix  = pix;
    w.tdc  = tdc;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] mk_trl(input logic             abort,
                                                input logic [CNT_W-1:0] hit_cnt,
                                                input logic [PIX_W-1:0] xsum);
    trl_word_t w;
    w.typ     = TYPE_TRL;
    w.abort   = abort;
    w.hit_cnt = hit_cnt;
    w.xsum    = xsum;
    w.rsvd    = '0;
    return w;
  endfunction

endpackage

// File: rtl/stream_word_fifo.sv
// Synchronous first-word-fall-through FIFO; a read at full lets a same-cycle write through.
module stream_word_fifo #(
  parameter int unsigned AW = 6,
  parameter int unsigned W  = 40
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] din,
  input  logic         rd_en,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_rd;
  logic          do_wr;

  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Head word is forced to zero while empty so the output is defined out of reset.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/l1_event_frame_builder.sv
// Frames the L1 hit stream into header/data/trailer words in a stream FIFO and raises
// almost-full back-pressure toward the L1 event buffer.
module l1_event_frame_builder
  import etroc_stream_pkg::*;
#(
  parameter int unsigned FIFO_AW   = 6,
  parameter int unsigned AF_THRESH = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              eventStart,
  input  logic              hit,
  input  logic [PIX_W-1:0]  pixelID,
  input  logic [TDC_W-1:0]  TDCData,
  input  logic [BCID_W-1:0] BCIDin,
  input  logic [L1_W-1:0]   L1Counter,
  input  logic              rd_en,
  output logic [WORD_W-1:0] dout,
  output logic              empty,
  output logic              streamBufAlmostFull,
  output logic              overflowErr,
  output logic [7:0]        dropCount
);

  state_t           state;
  state_t           state_nxt;
  logic [L1_W-1:0]  l1_lat,   l1_lat_nxt;
  logic [CNT_W-1:0] hit_cnt,  hit_cnt_nxt;
  logic [PIX_W-1:0] xsum,     xsum_nxt;
  logic [PIX_W-1:0] last_pix, last_pix_nxt;
  logic             last_vld, last_vld_nxt;

  logic              wr_en_c;
  logic [WORD_W-1:0] word_c;
  logic              full;
  logic [FIFO_AW:0]  fifo_count;
  logic              drop_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, per-event bookkeeping and the single FIFO write of this cycle.
  always_comb begin
    state_nxt    = state;
    l1_lat_nxt   = l1_lat;
    hit_cnt_nxt  = hit_cnt;
    xsum_nxt     = xsum;
    last_pix_nxt = last_pix;
    last_vld_nxt = last_vld;
    wr_en_c      = 1'b0;
    word_c       = '0;
    case (state)
      S_IDLE: begin
        if (eventStart) begin
          state_nxt    = S_HDR;
          l1_lat_nxt   = L1Counter;
          hit_cnt_nxt  = '0;
          xsum_nxt     = '0;
          last_vld_nxt = 1'b0;
        end
      end
      S_HDR, S_DATA: begin
        if (eventStart) begin
          // Upstream abort: close the open event and start the next one.
          wr_en_c      = 1'b1;
          word_c       = mk_trl(1'b1, hit_cnt, xsum);
          state_nxt    = S_HDR;
          l1_lat_nxt   = L1Counter;
          hit_cnt_nxt  = '0;
          xsum_nxt     = '0;
          last_vld_nxt = 1'b0;
        end else if (state == S_HDR) begin
          wr_en_c   = 1'b1;
          word_c    = mk_hdr(l1_lat, BCIDin);
          state_nxt = S_DATA;
        end else if (hit) begin
          // A repeated pixel is an upstream stall, not a new hit.
          if (!last_vld || (pixelID != last_pix)) begin
            wr_en_c      = 1'b1;
            word_c       = mk_data(pixelID, TDCData);
            last_pix_nxt = pixelID;
            last_vld_nxt = 1'b1;
            hit_cnt_nxt  = hit_cnt + CNT_W'(1);
            xsum_nxt     = xsum ^ pixelID;
          end
        end else begin
          wr_en_c   = 1'b1;
          word_c    = mk_trl(1'b0, hit_cnt, xsum);
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l1_lat   <= '0;
      hit_cnt  <= '0;
      xsum     <= '0;
      last_pix <= '0;
      last_vld <= 1'b0;
    end else begin
      l1_lat   <= l1_lat_nxt;
      hit_cnt  <= hit_cnt_nxt;
      xsum     <= xsum_nxt;
      last_pix <= last_pix_nxt;
      last_vld <= last_vld_nxt;
    end
  end

  stream_word_fifo #(
    .AW (FIFO_AW),
    .W  (WORD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_en_c),
    .din   (word_c),
    .rd_en (rd_en),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // A write into a full FIFO survives only if a pop frees the slot in the same cycle.
  assign drop_c = wr_en_c && full && !rd_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streamBufAlmostFull <= 1'b0;
      overflowErr         <= 1'b0;
      dropCount           <= '0;
    end else begin
      streamBufAlmostFull <= (fifo_count >= (FIFO_AW + 1)'(AF_THRESH));
      if (drop_c) begin
        overflowErr <= 1'b1;
        if (dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_l1_event_frame_builder.sv
// Directed bench for l1_event_frame_builder: expected frame words are queued and checked on drain.
module tb_l1_event_frame_builder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        eventStart = 1'b0;
  logic        hit = 1'b0;
  logic [7:0]  pixelID = 8'd0;
  logic [28:0] TDCData = 29'd0;
  logic [11:0] BCIDin = 12'd0;
  logic [7:0]  L1Counter = 8'd0;
  logic        rd_en = 1'b0;
  logic [39:0] dout;
  logic        empty;
  logic        streamBufAlmostFull;
  logic        overflowErr;
  logic [7:0]  dropCount;

  int nvec = 0;
  int nerr = 0;
  logic [39:0] expq[$];

  always #5 clk = ~clk;

  l1_event_frame_builder dut (
    .clk                 (clk),
    .reset               (reset),
    .eventStart          (eventStart),
    .hit                 (hit),
    .pixelID             (pixelID),
    .TDCData             (TDCData),
    .BCIDin              (BCIDin),
    .L1Counter           (L1Counter),
    .rd_en               (rd_en),
    .dout                (dout),
    .empty               (empty),
    .streamBufAlmostFull (streamBufAlmostFull),
    .overflowErr         (overflowErr),
    .dropCount           (dropCount)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] w_hdr(input logic [7:0] l1, input logic [11:0] bc);
    return {2'b11, 6'd0, l1, bc, 12'hA5C};
  endfunction

  function automatic logic [39:0] w_data(input logic [7:0] pix, input logic [28:0] tdc);
    return {2'b10, 1'b0, pix, tdc};
  endfunction

  function automatic logic [39:0] w_trl(input logic ab, input logic [8:0] cnt, input logic [7:0] xs);
    return {2'b01, ab, cnt, xs, 20'd0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev_open(input logic [7:0] l1, input logic [11:0] bc);
    eventStart = 1'b1;
    L1Counter  = l1;
    tick();
    eventStart = 1'b0;
    BCIDin     = bc;
    tick();
    expq.push_back(w_hdr(l1, bc));
  endtask

  task automatic put_hit(input logic [7:0] pix, input logic [28:0] tdc, input bit push);
    hit     = 1'b1;
    pixelID = pix;
    TDCData = tdc;
    tick();
    if (push) expq.push_back(w_data(pix, tdc));
  endtask

  task automatic ev_close(input logic [8:0] cnt, input logic [7:0] xs);
    hit = 1'b0;
    tick();
    expq.push_back(w_trl(1'b0, cnt, xs));
  endtask

  task automatic drain(input string tag, input int n);
    logic [39:0] w;
    for (int i = 0; i < n; i++) begin
      w = expq.pop_front();
      chk({tag, "_nonempty"}, 64'(empty), 64'(0));
      chk({tag, "_word"}, 64'(dout), 64'(w));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    if (expq.size() == 0) chk({tag, "_empty_after"}, 64'(empty), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_m;

    #2;
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_af", 64'(streamBufAlmostFull), 64'(0));
    chk("rst_ovf", 64'(overflowErr), 64'(0));
    chk("rst_drop", 64'(dropCount), 64'(0));
    tick();
    tick();
    reset = 1'b1;
    tick();

    // 1: three-hit event
    ev_open(8'h07, 12'h123);
    chk("t1_hdr_const", 64'(expq[0]), 64'h00C0_0712_3A5C);
    put_hit(8'd5, 29'h0000_1111, 1'b1);
    put_hit(8'd9, 29'h0ABC_DEF0, 1'b1);
    put_hit(8'd200, 29'h1FFF_FFFF, 1'b1);
    hit = 1'b0;
    tick();
    expq.push_back(40'h40_3C40_0000);
    drain("t1", 5);

    // 2: zero-hit event
    ev_open(8'h08, 12'hFFF);
    ev_close(9'd0, 8'h00);
    drain("t2", 2);

    // 3: stalled repeat of pixel 17
    ev_open(8'h09, 12'h001);
    put_hit(8'd17, 29'h0000_0042, 1'b1);
    for (int i = 0; i < 3; i++) put_hit(8'd17, 29'h0000_0042, 1'b0);
    ev_close(9'd1, 8'h11);
    drain("t3", 3);

    // 4: abort by eventStart during DATA
    ev_open(8'h21, 12'h456);
    put_hit(8'd3, 29'h0000_0003, 1'b1);
    put_hit(8'd4, 29'h0000_0004, 1'b1);
    hit        = 1'b0;
    eventStart = 1'b1;
    L1Counter  = 8'h22;
    tick();
    expq.push_back(w_trl(1'b1, 9'd2, 8'h07));
    eventStart = 1'b0;
    L1Counter  = 8'h99;
    BCIDin     = 12'h789;
    tick();
    expq.push_back(w_hdr(8'h22, 12'h789));
    ev_close(9'd0, 8'h00);
    drain("t4", 6);

    // 5: fill to full, drop, simultaneous read+write at full
    ev_open(8'h30, 12'hABC);
    cnt_m = 1;
    for (int i = 1; i <= 63; i++) begin
      put_hit(8'(i), 29'(i * 3), 1'b1);
      chk("t5_af_fill", 64'(streamBufAlmostFull), 64'(cnt_m >= 48));
      cnt_m++;
    end
    chk("t5_ovf_before", 64'(overflowErr), 64'(0));
    chk("t5_drop_before", 64'(dropCount), 64'(0));
    put_hit(8'd64, 29'h0000_0777, 1'b0);
    chk("t5_ovf_set", 64'(overflowErr), 64'(1));
    chk("t5_drop_1", 64'(dropCount), 64'(1));
    chk("t5_full_head", 64'(dout), 64'(expq.pop_front()));
    rd_en = 1'b1;
    put_hit(8'd65, 29'h0000_0888, 1'b1);
    rd_en = 1'b0;
    chk("t5_simul_nodrop", 64'(dropCount), 64'(1));
    hit = 1'b0;
    tick();
    chk("t5_trl_drop", 64'(dropCount), 64'(2));
    chk("t5_af_full", 64'(streamBufAlmostFull), 64'(1));
    drain("t5", 10);

    // 6: reset mid-DATA
    ev_open(8'h44, 12'h555);
    put_hit(8'd1, 29'h0000_0001, 1'b0);
    put_hit(8'd2, 29'h0000_0002, 1'b0);
    chk("t6_af_pre", 64'(streamBufAlmostFull), 64'(1));
    reset = 1'b0;
    #1;
    chk("t6_rst_empty", 64'(empty), 64'(1));
    chk("t6_rst_af", 64'(streamBufAlmostFull), 64'(0));
    chk("t6_rst_ovf", 64'(overflowErr), 64'(0));
    chk("t6_rst_drop", 64'(dropCount), 64'(0));
    chk("t6_rst_dout", 64'(dout), 64'(0));
    expq.delete();
    tick();
    reset = 1'b1;
    put_hit(8'd7, 29'h0000_0007, 1'b0);
    put_hit(8'd8, 29'h0000_0008, 1'b0);
    hit = 1'b0;
    tick();
    chk("t6_idle_nowrite", 64'(empty), 64'(1));
    ev_open(8'h45, 12'h666);
    put_hit(8'h10, 29'h0000_0100, 1'b1);
    put_hit(8'h20, 29'h0000_0200, 1'b1);
    ev_close(9'd2, 8'h30);
    drain("t6", 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
